// File: rtl/bin2bcd_seg_display.sv
// bin2bcd_seg_display
//   Sequential binary-to-decimal converter driving active-low 7-segment
//   displays. A W-bit value is captured on start and converted with the
//   shift-and-add-3 method, one bit per clock. Results are registered and
//   held until the next conversion completes or reset.
//
// Ports
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous, active-high
//   start    : conversion request, honoured only when idle
//   bin      : W-bit unsigned value captured when start is accepted
//   busy     : high while shifting
//   done     : one-cycle pulse when bcd/HEX/ovf take new values
//   ovf      : captured value was >= 10^DIGITS
//   bcd      : packed BCD, digit 0 in [3:0]
//   HEX      : packed segments gfedcba, active-low, display 0 in [6:0]
module bin2bcd_seg_display #(
  parameter int unsigned W             = 9,
  parameter int unsigned DIGITS        = 3,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   HEX
);

  // Decimal digits needed to hold 2^w - 1.
  function automatic int unsigned dec_digits(input int unsigned w);
    longint unsigned maxv;
    int unsigned     n;
    maxv = (64'd1 << w) - 64'd1;
    n    = 1;
    for (int unsigned i = 0; i < 8; i++) begin
      if (maxv >= 64'd10) begin
        maxv = maxv / 64'd10;
        n    = n + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  localparam int unsigned ACC_MIN = dec_digits(W);
  localparam int unsigned NACC    = (ACC_MIN > DIGITS) ? ACC_MIN : DIGITS;
  localparam int unsigned CW      = $clog2(W + 1);
  localparam logic [31:0] LIMIT   = pow10(DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          shreg_q, shreg_d;
  logic [4*NACC-1:0]     acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [7*DIGITS-1:0]   hex_q, hex_d;

  logic [4*NACC-1:0]     adj;
  logic [4*NACC+W-1:0]   shifted;
  logic [7*DIGITS-1:0]   hex_fin;

  // Add-3 correction followed by a one-bit left shift of {acc, shreg}.
  always_comb begin
    adj = acc_q;
    for (int unsigned i = 0; i < NACC; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj, shreg_q} << 1;
  end

  // Display codes from the finished accumulator. Scanning from the top digit
  // down lets zero_above track "this and all higher digits are zero".
  always_comb begin
    logic        zero_above;
    logic [3:0]  nib;
    int unsigned d;
    zero_above = 1'b1;
    nib        = '0;
    d          = 0;
    hex_fin    = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      d          = DIGITS - 1 - k;
      nib        = acc_q[4*d +: 4];
      zero_above = zero_above && (nib == 4'd0);
      if (ovf_pend_q) begin
        hex_fin[7*d +: 7] = 7'b0111111;
      end else if ((BLANK_LEADING != 0) && (d != 0) && zero_above) begin
        hex_fin[7*d +: 7] = '1;
      end else begin
        hex_fin[7*d +: 7] = seg7(nib);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    hex_d      = hex_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d    = bin;
          acc_d      = '0;
          cnt_d      = CW'(W);
          ovf_pend_d = (32'(bin) >= LIMIT);
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        acc_d   = shifted[4*NACC+W-1:W];
        shreg_d = shifted[W-1:0];
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FINISH;
        end else begin
          busy_d  = 1'b1;
        end
      end
      FINISH: begin
        bcd_d   = acc_q[4*DIGITS-1:0];
        hex_d   = hex_fin;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      hex_q      <= '1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      hex_q      <= hex_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;
  assign HEX  = hex_q;

endmodule

// File: tb/tb_bin2bcd_seg_display.sv
// Testbench for bin2bcd_seg_display. Two instances share clock, reset, start
// and bin: A uses the default parameters (W=9, blanking on), B uses W=10 with
// blanking off. Each accepted start pushes the expected display state into a
// per-instance queue; the checker pops on every done pulse and compares all
// outputs every cycle against the current expectation.
module tb_bin2bcd_seg_display;

  localparam int unsigned W_A = 9;
  localparam int unsigned W_B = 10;

  typedef struct packed {
    logic [11:0] bcd;
    logic [20:0] hex;
    logic        ovf;
  } exp_t;

  localparam exp_t RESET_EXP = '{bcd: 12'h000, hex: {21{1'b1}}, ovf: 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  bin;

  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [11:0] bcd_a, bcd_b;
  logic [20:0] hex_a, hex_b;

  always #5 clk = ~clk;

  bin2bcd_seg_display #(.W(W_A), .DIGITS(3), .BLANK_LEADING(1)) u_a (
    .CLOCK_50(clk), .reset(reset), .start(start), .bin(bin[8:0]),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .bcd(bcd_a), .HEX(hex_a)
  );

  bin2bcd_seg_display #(.W(W_B), .DIGITS(3), .BLANK_LEADING(0)) u_b (
    .CLOCK_50(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .bcd(bcd_b), .HEX(hex_b)
  );

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  // Decimal digits by division; a digit above display 0 is a leading zero
  // exactly when the value is smaller than its place value.
  function automatic exp_t ref_model(input int unsigned v, input bit blank);
    exp_t        e;
    int unsigned p;
    int unsigned nib;
    e.ovf = (v >= 1000);
    p     = 1;
    for (int d = 0; d < 3; d++) begin
      nib            = (v / p) % 10;
      e.bcd[4*d +: 4] = 4'(nib);
      if (e.ovf)                        e.hex[7*d +: 7] = 7'b0111111;
      else if (blank && d > 0 && v < p) e.hex[7*d +: 7] = 7'b1111111;
      else                              e.hex[7*d +: 7] = seg_tab[nib];
      p = p * 10;
    end
    return e;
  endfunction

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s[%s] t=%0t: got %h expected %h", name,
               (inst == 0) ? "A" : "B", $time, act, exp_v);
    end
  endtask

  exp_t        sb_q [2][$];
  exp_t        cur_exp [2];
  int unsigned rem [2];
  bit          done_exp [2];
  bit          check_en   = 1'b0;
  bit          finish_req = 1'b0;

  // Reference timeline + checker in one process: the posedge half models
  // acceptance and latency, the negedge half samples the DUTs.
  always begin
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      done_exp[i] = 1'b0;
      if (reset) begin
        rem[i] = 0;
        sb_q[i].delete();
        cur_exp[i] = RESET_EXP;
      end else if (rem[i] != 0) begin
        rem[i] = rem[i] - 1;
        if (rem[i] == 0) done_exp[i] = 1'b1;
      end else if (start) begin
        rem[i] = ((i == 0) ? W_A : W_B) + 1;
        sb_q[i].push_back(ref_model((i == 0) ? int'(bin[8:0]) : int'(bin),
                                    (i == 0)));
      end
    end
    if (reset) check_en = 1'b1;

    @(negedge clk);
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        logic        d_done, d_busy, d_ovf;
        logic [11:0] d_bcd;
        logic [20:0] d_hex;
        d_done = (i == 0) ? done_a : done_b;
        d_busy = (i == 0) ? busy_a : busy_b;
        d_ovf  = (i == 0) ? ovf_a  : ovf_b;
        d_bcd  = (i == 0) ? bcd_a  : bcd_b;
        d_hex  = (i == 0) ? hex_a  : hex_b;
        chk("done", i, 32'(d_done), 32'(done_exp[i]));
        if (d_done === 1'b1) begin
          chk("sb_nonempty", i, 32'(sb_q[i].size() != 0), 32'd1);
          if (sb_q[i].size() != 0) cur_exp[i] = sb_q[i].pop_front();
        end
        chk("bcd",  i, 32'(d_bcd),  32'(cur_exp[i].bcd));
        chk("hex",  i, 32'(d_hex),  32'(cur_exp[i].hex));
        chk("ovf",  i, 32'(d_ovf),  32'(cur_exp[i].ovf));
        chk("busy", i, 32'(d_busy), 32'(rem[i] >= 2));
      end
    end
    if (finish_req) begin
      for (int i = 0; i < 2; i++) chk("sb_drained", i, 32'(sb_q[i].size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  task automatic convert(input int unsigned v);
    @(negedge clk);
    bin   = 10'(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
  endtask

  int unsigned edge_vals [9] = '{0, 9, 10, 99, 100, 511, 999, 1000, 1023};

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    convert(511);
    convert(7);
    convert(0);
    convert(1000);
    convert(999);

    // start held 20 cycles; bin changes to 45 while the first is shifting
    @(negedge clk);
    bin   = 10'd123;
    start = 1'b1;
    repeat (3) @(negedge clk);
    bin = 10'd45;
    repeat (17) @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);

    // reset in the middle of a conversion, then a clean one
    @(negedge clk);
    bin   = 10'd876;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    convert(305);

    // random start pulses, including ones that land while busy
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) bin = 10'(edge_vals[$urandom_range(0, 8)]);
      else                           bin = 10'($urandom_range(0, 1023));
    end
    start = 1'b0;
    repeat (15) @(negedge clk);

    finish_req = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL watchdog: checker did not terminate, got running expected stopped");
    $fatal(1);
  end

endmodule
